dac_sample_scheduler: RTL and testbench

Sits between the rvmyth core's 10-bit OUT bus and the on-chip DAC input. It captures every new core output value into a small FIFO. It replays the captured values to the DAC at a programmable, fixed sample rate. This decouples the core's irregular write timing from the DAC's uniform update period. It also reports overflow and underrun to the management side.

---
 rtl/dac_sample_scheduler.sv | 145 ++++++++++++++
 tb/tb_dac_sample_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_sample_scheduler.sv
// Sample scheduler between the rvmyth OUT bus and the DAC input.
// Captures each new core output into a small FIFO and replays the queued
// samples to the DAC at a fixed, programmable period. The FIFO must fill to
// half depth before playback starts, which gives the core some slack.
module dac_sample_scheduler #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DIV_W  = 16
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      core_out,
  input  logic                   enable,
  input  logic [DIV_W-1:0]       div,
  input  logic                   clr_flags,
  output logic [DATA_W-1:0]      dac_data,
  output logic                   dac_strobe,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic                   underrun,
  output logic [1:0]             state_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] Full = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] Half = CNT_W'(DEPTH / 2);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StPrime = 2'd1;
  localparam logic [1:0] StRun   = 2'd2;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] last_q;
  logic [DATA_W-1:0] dac_data_q;
  logic              dac_strobe_q;
  logic              overflow_q, underrun_q;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        state_q, state_d;
  logic              push, tick, pop, accept, drop, starve;

  // Change detect and sample-period divider; the divider is frozen at 0 in IDLE.
  always_comb begin
    push  = enable && (core_out != last_q);
    tick  = 1'b0;
    cnt_d = '0;
    if (enable && (state_q != StIdle)) begin
      // >= so that lowering div below the running count ticks right away
      tick  = (cnt_q >= div);
      cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
    end
  end

  // Playback FSM: decides when a tick pops and when the FIFO has starved.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    starve  = 1'b0;
    if (!enable) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  state_d = StPrime;
        StPrime: begin
          if (tick && (count_q >= Half)) begin
            pop     = 1'b1;
            state_d = StRun;
          end
        end
        StRun: begin
          if (tick) begin
            if (count_q != '0) begin
              pop = 1'b1;
            end else begin
              starve  = 1'b1;
              state_d = StPrime;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // FIFO occupancy; a pop frees a slot for a push in the same cycle.
  always_comb begin
    accept  = push && ((count_q != Full) || pop);
    drop    = push && !accept;
    count_d = count_q;
    if (accept && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!accept && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge CLK) begin
    if (!reset && accept) begin
      mem[wr_ptr_q] <= core_out;
    end
  end

  // Control state, pointers, output register and sticky flags.
  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_q       <= '0;
      dac_data_q   <= '0;
      dac_strobe_q <= 1'b0;
      overflow_q   <= 1'b0;
      underrun_q   <= 1'b0;
      cnt_q        <= '0;
      state_q      <= StIdle;
    end else begin
      last_q       <= core_out;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      count_q      <= count_d;
      dac_strobe_q <= pop;
      if (accept) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
        dac_data_q <= mem[rd_ptr_q];
      end
      // A new event wins over a coincident clear.
      overflow_q <= drop || (overflow_q && !clr_flags);
      underrun_q <= starve || (underrun_q && !clr_flags);
    end
  end

  assign dac_data   = dac_data_q;
  assign dac_strobe = dac_strobe_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign underrun   = underrun_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Bench for dac_sample_scheduler: directed scenarios followed by random
// stimulus, every cycle compared against a queue-based behavioural model.
module tb_dac_sample_scheduler;

  localparam int DATA_W = 10;
  localparam int DEPTH  = 8;
  localparam int DIV_W  = 16;

  logic              CLK = 1'b0;
  logic              reset, enable, clr_flags;
  logic [DATA_W-1:0] core_out;
  logic [DIV_W-1:0]  div;
  logic [DATA_W-1:0] dac_data;
  logic              dac_strobe, overflow, underrun;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [1:0]        state_o;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int m_q[$];
  int m_state, m_cnt, m_last, m_dac;
  bit m_strobe, m_ovf, m_und;
  int strobed[$];

  always #5 CLK = ~CLK;

  dac_sample_scheduler #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .DIV_W (DIV_W)
  ) dut (
    .CLK       (CLK),
    .reset     (reset),
    .core_out  (core_out),
    .enable    (enable),
    .div       (div),
    .clr_flags (clr_flags),
    .dac_data  (dac_data),
    .dac_strobe(dac_strobe),
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .underrun  (underrun),
    .state_o   (state_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the scheduler, applied to the model.
  task automatic model_edge();
    bit push, tick, pop, ovf_set, und_set;
    int nstate;
    if (reset) begin
      m_q.delete();
      m_state  = 0;
      m_cnt    = 0;
      m_last   = 0;
      m_dac    = 0;
      m_strobe = 0;
      m_ovf    = 0;
      m_und    = 0;
      return;
    end
    push   = enable && (int'(core_out) != m_last);
    m_last = int'(core_out);
    tick   = 0;
    if (enable && m_state != 0) begin
      tick  = (m_cnt >= int'(div));
      m_cnt = tick ? 0 : m_cnt + 1;
    end else begin
      m_cnt = 0;
    end
    pop     = 0;
    und_set = 0;
    nstate  = m_state;
    if (!enable) begin
      nstate = 0;
    end else if (m_state == 0) begin
      nstate = 1;
    end else if (tick) begin
      if (m_state == 1) begin
        if (m_q.size() >= DEPTH / 2) begin
          pop    = 1;
          nstate = 2;
        end
      end else if (m_q.size() > 0) begin
        pop = 1;
      end else begin
        und_set = 1;
        nstate  = 1;
      end
    end
    m_strobe = pop;
    if (pop) m_dac = m_q.pop_front();
    ovf_set = 0;
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back(int'(core_out));
      else ovf_set = 1;
    end
    m_ovf   = ovf_set || (m_ovf && !clr_flags);
    m_und   = und_set || (m_und && !clr_flags);
    m_state = nstate;
  endtask

  task automatic step(input string tag);
    @(posedge CLK);
    model_edge();
    #1;
    if (dac_strobe === 1'b1) strobed.push_back(int'(dac_data));
    chk({tag, ".data"},   32'(dac_data),   32'(m_dac));
    chk({tag, ".strobe"}, 32'(dac_strobe), 32'(m_strobe));
    chk({tag, ".count"},  32'(fifo_count), 32'(m_q.size()));
    chk({tag, ".ovf"},    32'(overflow),   32'(m_ovf));
    chk({tag, ".und"},    32'(underrun),   32'(m_und));
    chk({tag, ".state"},  32'(state_o),    32'(m_state));
  endtask

  task automatic run(input int n, input string tag);
    repeat (n) step(tag);
  endtask

  initial begin
    bit seen_run, found;
    reset = 1; enable = 0; clr_flags = 0; core_out = '0; div = '0;
    run(2, "rst");
    chk("rst.data", 32'(dac_data), 0);
    chk("rst.count", 32'(fifo_count), 0);
    chk("rst.state", 32'(state_o), 0);
    chk("rst.flags", 32'({overflow, underrun, dac_strobe}), 0);
    reset = 0;

    // Steady value is captured once
    enable = 1; div = 100; core_out = 10'h155;
    run(20, "hold");
    chk("hold.count", 32'(fifo_count), 1);

    // Four stepped values replayed every 4 cycles, then starvation
    reset = 1; run(1, "rst2"); reset = 0;
    div = 3; strobed.delete();
    for (int i = 1; i <= 4; i++) begin
      core_out = DATA_W'(i);
      step("seq");
    end
    run(24, "seq");
    chk("seq.n", 32'(strobed.size()), 4);
    for (int i = 0; i < 4 && i < strobed.size(); i++) chk("seq.val", 32'(strobed[i]), 32'(i + 1));
    chk("seq.und", 32'(underrun), 1);
    chk("seq.state", 32'(state_o), 1);
    chk("seq.hold", 32'(dac_data), 4);
    clr_flags = 1; step("clr"); clr_flags = 0;
    chk("clr.und", 32'(underrun), 0);

    // Clear held high across a fresh underrun: the set must win
    div = 0; clr_flags = 1; seen_run = 0; found = 0;
    for (int i = 0; i < 4; i++) begin
      core_out = DATA_W'(40 + i);
      step("coinc");
    end
    for (int k = 0; k < 20 && !found; k++) begin
      step("coinc");
      if (state_o == 2) seen_run = 1;
      else if (seen_run && state_o == 1) found = 1;
    end
    chk("coinc.found", 32'(found), 1);
    chk("coinc.und", 32'(underrun), 1);
    clr_flags = 0;

    // Divider lowered below the running count ticks on the next cycle
    reset = 1; run(1, "rst3"); reset = 0;
    div = 50; strobed.delete();
    for (int i = 0; i < 4; i++) begin
      core_out = DATA_W'(200 + i);
      step("div");
    end
    run(26, "div");
    chk("div.nostrobe", 32'(strobed.size()), 0);
    div = 2;
    step("div2");
    chk("div2.strobe", 32'(dac_strobe), 1);
    chk("div2.data", 32'(dac_data), 200);
    run(3, "div2");
    chk("div2.period", 32'(dac_strobe), 1);

    // Enable drop goes idle immediately and keeps the FIFO
    enable = 0;
    step("off");
    chk("off.state", 32'(state_o), 0);
    chk("off.count", 32'(fifo_count), 2);
    run(6, "off");
    chk("off.strobe", 32'(dac_strobe), 0);

    // Reset mid-RUN with five entries queued
    enable = 1; div = 1000;
    for (int i = 0; i < 4; i++) begin
      core_out = DATA_W'(300 + i);
      step("rr");
    end
    div = 0;
    step("rr");
    chk("rr.state", 32'(state_o), 2);
    chk("rr.count", 32'(fifo_count), 5);
    reset = 1; step("rr.rst"); reset = 0;
    chk("rr.rcount", 32'(fifo_count), 0);
    chk("rr.rstate", 32'(state_o), 0);
    run(4, "rr.after");

    // Overflow: 12 pushes into 8 entries with a slow divider
    reset = 1; run(1, "rst4"); reset = 0;
    div = 100; strobed.delete();
    for (int i = 0; i < 12; i++) begin
      core_out = DATA_W'(16 + i);
      step("ovf");
    end
    chk("ovf.flag", 32'(overflow), 1);
    chk("ovf.count", 32'(fifo_count), 8);
    div = 0;
    run(12, "ovf.drain");
    chk("ovf.n", 32'(strobed.size()), 8);
    for (int i = 0; i < 8 && i < strobed.size(); i++) chk("ovf.val", 32'(strobed[i]), 32'(16 + i));

    // Back-to-back pushes with div=0: playback keeps up, no overflow
    reset = 1; run(1, "rst5"); reset = 0;
    div = 0; strobed.delete();
    for (int i = 0; i < 12; i++) begin
      core_out = DATA_W'(100 + i);
      step("b2b");
    end
    run(10, "b2b");
    chk("b2b.ovf", 32'(overflow), 0);
    chk("b2b.n", 32'(strobed.size()), 12);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      enable    = ($urandom_range(0, 9) != 0);
      clr_flags = ($urandom_range(0, 9) == 0);
      core_out  = DATA_W'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) div = DIV_W'($urandom_range(0, 4));
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
